// File: rtl/mesi_snoop_ctrl.sv
// mesi_snoop_ctrl: snoop-side MESI coherence responder for the L1 data cache
module mesi_snoop_ctrl #(
    parameter int TAG_BITS      = 5,
    parameter int INDEX_BITS    = 3,
    parameter int OFFSET_BITS   = 4,
    parameter int FLUSH_TIMEOUT = 15
) (
    input  logic                                      clk,
    input  logic                                      nrst,
    input  logic                                      i_snp_valid,
    output logic                                      o_snp_ready,
    input  logic [1:0]                                i_snp_cmd,
    input  logic [TAG_BITS+INDEX_BITS+OFFSET_BITS-1:0] i_snp_addr,
    output logic [TAG_BITS-1:0]                       o_lkup_tag,
    output logic [INDEX_BITS-1:0]                     o_lkup_index,
    input  logic                                      i_lkup_hit,
    input  logic [1:0]                                i_lkup_mesi,
    output logic                                      o_set_invalidate,
    output logic                                      o_set_shared,
    output logic                                      o_flush_req,
    input  logic                                      i_flush_done,
    output logic                                      o_resp_valid,
    output logic                                      o_resp_shared,
    output logic                                      o_resp_dirty,
    output logic                                      o_proto_err,
    output logic                                      o_busy
);
    localparam int ADDR_BITS = TAG_BITS + INDEX_BITS + OFFSET_BITS;
    localparam int CNT_BITS  = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_UPGR = 2'b11;
    localparam logic [1:0] ST_S     = 2'b01;
    localparam logic [1:0] ST_M     = 2'b10;

    typedef enum logic [2:0] {IDLE, LOOKUP, FLUSH, UPDATE, RESP} state_t;

    state_t                state_q, state_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [INDEX_BITS-1:0] index_q, index_d;
    logic [1:0]            cmd_q, cmd_d;
    logic                  hit_q, hit_d;
    logic [1:0]            mesi_q, mesi_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  dirty_q, dirty_d;
    logic [CNT_BITS-1:0]   cnt_inc;

    // the byte offset never matters for a line-granular snoop
    logic unused_offset;
    assign unused_offset = ^i_snp_addr[OFFSET_BITS-1:0];

    assign cnt_inc = cnt_q + CNT_BITS'(1);

    // state register and latched transaction context
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            index_q   <= '0;
            cmd_q     <= '0;
            hit_q     <= 1'b0;
            mesi_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            dirty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            index_q   <= index_d;
            cmd_q     <= cmd_d;
            hit_q     <= hit_d;
            mesi_q    <= mesi_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            dirty_q   <= dirty_d;
        end
    end

    // next-state: accept, classify the lookup, wait for writeback, then update and respond
    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        index_d   = index_q;
        cmd_d     = cmd_q;
        hit_d     = hit_q;
        mesi_d    = mesi_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        dirty_d   = dirty_q;
        case (state_q)
            IDLE: begin
                if (i_snp_valid) begin
                    tag_d   = i_snp_addr[ADDR_BITS-1 -: TAG_BITS];
                    index_d = i_snp_addr[OFFSET_BITS +: INDEX_BITS];
                    cmd_d   = i_snp_cmd;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d     = i_lkup_hit;
                mesi_d    = i_lkup_mesi;
                cnt_d     = '0;
                timeout_d = 1'b0;
                dirty_d   = 1'b0;
                if (cmd_q == CMD_NOP || !i_lkup_hit || (i_lkup_mesi == ST_S && cmd_q == CMD_RD))
                    state_d = RESP;
                else
                    state_d = (i_lkup_mesi == ST_M) ? FLUSH : UPDATE;
            end
            FLUSH: begin
                cnt_d = cnt_inc;
                if (i_flush_done) begin
                    dirty_d = 1'b1;
                    state_d = UPDATE;
                end else if (cnt_inc == CNT_BITS'(FLUSH_TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = UPDATE;
                end
            end
            UPDATE:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_snp_ready      = (state_q == IDLE);
    assign o_busy           = (state_q != IDLE);
    assign o_lkup_tag       = tag_q;
    assign o_lkup_index     = index_q;
    assign o_flush_req      = (state_q == FLUSH);
    assign o_set_shared     = (state_q == UPDATE) && (cmd_q == CMD_RD);
    assign o_set_invalidate = (state_q == UPDATE) && (cmd_q != CMD_RD);
    assign o_resp_valid     = (state_q == RESP);
    assign o_resp_shared    = (state_q == RESP) && hit_q;
    assign o_resp_dirty     = (state_q == RESP) && dirty_q;
    assign o_proto_err      = (state_q == RESP) &&
                              ((hit_q && cmd_q == CMD_UPGR && mesi_q[1]) || timeout_q);
endmodule

// File: tb/tb_mesi_snoop_ctrl.sv
// tb_mesi_snoop_ctrl: directed scenarios for the MESI snoop responder
module tb_mesi_snoop_ctrl;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        snp_valid = 1'b0;
    logic        o_snp_ready;
    logic [1:0]  snp_cmd = 2'b00;
    logic [11:0] snp_addr = '0;
    logic [4:0]  o_lkup_tag;
    logic [2:0]  o_lkup_index;
    logic        lkup_hit = 1'b0;
    logic [1:0]  lkup_mesi = 2'b00;
    logic        o_set_invalidate, o_set_shared, o_flush_req;
    logic        flush_done = 1'b0;
    logic        o_resp_valid, o_resp_shared, o_resp_dirty, o_proto_err, o_busy;

    int checks = 0;
    int errors = 0;

    mesi_snoop_ctrl dut (
        .clk(clk), .nrst(nrst),
        .i_snp_valid(snp_valid), .o_snp_ready(o_snp_ready),
        .i_snp_cmd(snp_cmd), .i_snp_addr(snp_addr),
        .o_lkup_tag(o_lkup_tag), .o_lkup_index(o_lkup_index),
        .i_lkup_hit(lkup_hit), .i_lkup_mesi(lkup_mesi),
        .o_set_invalidate(o_set_invalidate), .o_set_shared(o_set_shared),
        .o_flush_req(o_flush_req), .i_flush_done(flush_done),
        .o_resp_valid(o_resp_valid), .o_resp_shared(o_resp_shared),
        .o_resp_dirty(o_resp_dirty), .o_proto_err(o_proto_err), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // issue one snoop from IDLE and record what the DUT does, cycle 1 being LOOKUP
    // done_at: flush cycle on which to raise done (0 never, -1 held high throughout)
    task automatic run_txn(input logic [1:0] cmd, input logic [11:0] addr, input logic hit,
                           input logic [1:0] mesi, input int done_at,
                           output int rc, output int uc, output int ic, output int sc,
                           output int fc, output int bz, output logic [4:0] lt,
                           output logic [2:0] li, output logic rs, output logic rd,
                           output logic re);
        rc = -1; uc = -1; ic = 0; sc = 0; fc = 0; bz = 0;
        lt = '0; li = '0; rs = 0; rd = 0; re = 0;
        snp_valid = 1; snp_cmd = cmd; snp_addr = addr; lkup_hit = hit; lkup_mesi = mesi;
        flush_done = (done_at < 0);
        @(posedge clk); #1;
        snp_valid = 0;
        for (int c = 1; c <= 40 && rc < 0; c++) begin
            if (c == 1) begin lt = o_lkup_tag; li = o_lkup_index; end
            if (!o_busy) bz++;
            if (o_flush_req) fc++;
            if (done_at >= 0) flush_done = o_flush_req && (fc == done_at);
            if (o_set_invalidate) begin ic++; uc = c; end
            if (o_set_shared) begin sc++; uc = c; end
            if (o_resp_valid) begin
                rc = c; rs = o_resp_shared; rd = o_resp_dirty; re = o_proto_err;
            end
            @(posedge clk); #1;
        end
        flush_done = 0;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (o_snp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_snp_ready); end
        checks++; if ({o_busy, o_flush_req, o_set_invalidate, o_set_shared, o_resp_valid, o_resp_shared, o_resp_dirty, o_proto_err} !== 8'h00)
            begin errors++; $display("FAIL reset_outputs: got %b want 00000000", {o_busy, o_flush_req, o_set_invalidate, o_set_shared, o_resp_valid, o_resp_shared, o_resp_dirty, o_proto_err}); end
        checks++; if ({o_lkup_tag, o_lkup_index} !== 8'h00) begin errors++; $display("FAIL reset_lkup: got %h want 00", {o_lkup_tag, o_lkup_index}); end
        @(negedge clk); nrst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_miss;
        int rc, uc, ic, sc, fc, bz; logic [4:0] lt; logic [2:0] li; logic rs, rd, re;
        run_txn(2'b01, 12'h1A4, 1'b0, 2'b00, 0, rc, uc, ic, sc, fc, bz, lt, li, rs, rd, re);
        checks++; if (lt !== 5'd3) begin errors++; $display("FAIL miss_tag: got %0d want 3", lt); end
        checks++; if (li !== 3'd2) begin errors++; $display("FAIL miss_index: got %0d want 2", li); end
        checks++; if (rc != 2) begin errors++; $display("FAIL miss_latency: got %0d want 2", rc); end
        checks++; if ({rs, rd, re} !== 3'b000) begin errors++; $display("FAIL miss_resp: got %b want 000", {rs, rd, re}); end
        checks++; if (ic + sc + fc != 0) begin errors++; $display("FAIL miss_no_action: got %0d want 0", ic + sc + fc); end
        checks++; if (bz != 0) begin errors++; $display("FAIL miss_busy: idle cycles %0d want 0", bz); end
        checks++; if ({o_lkup_tag, o_lkup_index} !== {5'd3, 3'd2}) begin errors++; $display("FAIL miss_lkup_hold: got %h want 1a", {o_lkup_tag, o_lkup_index}); end
    endtask

    task automatic test_invalidate_e;
        int rc, uc, ic, sc, fc, bz; logic [4:0] lt; logic [2:0] li; logic rs, rd, re;
        run_txn(2'b10, 12'h1A4, 1'b1, 2'b11, 0, rc, uc, ic, sc, fc, bz, lt, li, rs, rd, re);
        checks++; if (ic != 1 || sc != 0) begin errors++; $display("FAIL e_rdx_pulses: inv %0d sh %0d want 1 0", ic, sc); end
        checks++; if (uc != 2) begin errors++; $display("FAIL e_rdx_update_cycle: got %0d want 2", uc); end
        checks++; if (rc != 3) begin errors++; $display("FAIL e_rdx_latency: got %0d want 3", rc); end
        checks++; if ({rs, rd, re} !== 3'b100) begin errors++; $display("FAIL e_rdx_resp: got %b want 100", {rs, rd, re}); end
    endtask

    task automatic test_flush_done;
        int rc, uc, ic, sc, fc, bz; logic [4:0] lt; logic [2:0] li; logic rs, rd, re;
        run_txn(2'b01, 12'h3F0, 1'b1, 2'b10, 3, rc, uc, ic, sc, fc, bz, lt, li, rs, rd, re);
        checks++; if (fc != 3) begin errors++; $display("FAIL m_rd_flush_cycles: got %0d want 3", fc); end
        checks++; if (sc != 1 || ic != 0 || uc != 5) begin errors++; $display("FAIL m_rd_update: sh %0d inv %0d cyc %0d want 1 0 5", sc, ic, uc); end
        checks++; if (rc != 6) begin errors++; $display("FAIL m_rd_latency: got %0d want 6", rc); end
        checks++; if ({rs, rd, re} !== 3'b110) begin errors++; $display("FAIL m_rd_resp: got %b want 110", {rs, rd, re}); end
        run_txn(2'b10, 12'h3F0, 1'b1, 2'b10, 1, rc, uc, ic, sc, fc, bz, lt, li, rs, rd, re);
        checks++; if (fc != 1 || uc != 3 || rc != 4) begin errors++; $display("FAIL m_rdx_fast: flush %0d upd %0d resp %0d want 1 3 4", fc, uc, rc); end
        checks++; if (ic != 1 || {rs, rd, re} !== 3'b110) begin errors++; $display("FAIL m_rdx_fast_resp: inv %0d resp %b want 1 110", ic, {rs, rd, re}); end
    endtask

    task automatic test_flush_timeout;
        int rc, uc, ic, sc, fc, bz; logic [4:0] lt; logic [2:0] li; logic rs, rd, re;
        run_txn(2'b11, 12'h0A8, 1'b1, 2'b10, 0, rc, uc, ic, sc, fc, bz, lt, li, rs, rd, re);
        checks++; if (fc != 15) begin errors++; $display("FAIL timeout_flush_cycles: got %0d want 15", fc); end
        checks++; if (ic != 1 || sc != 0 || uc != 17) begin errors++; $display("FAIL timeout_update: inv %0d sh %0d cyc %0d want 1 0 17", ic, sc, uc); end
        checks++; if (rc != 18) begin errors++; $display("FAIL timeout_latency: got %0d want 18", rc); end
        checks++; if ({rs, rd, re} !== 3'b101) begin errors++; $display("FAIL timeout_resp: got %b want 101", {rs, rd, re}); end
        checks++; if (bz != 0) begin errors++; $display("FAIL timeout_busy: idle cycles %0d want 0", bz); end
    endtask

    task automatic test_other_hits;
        int rc, uc, ic, sc, fc, bz; logic [4:0] lt; logic [2:0] li; logic rs, rd, re;
        run_txn(2'b01, 12'h555, 1'b1, 2'b01, 0, rc, uc, ic, sc, fc, bz, lt, li, rs, rd, re);
        checks++; if (rc != 2 || ic + sc != 0 || {rs, rd, re} !== 3'b100) begin errors++; $display("FAIL s_rd: resp %0d pulses %0d flags %b want 2 0 100", rc, ic + sc, {rs, rd, re}); end
        run_txn(2'b01, 12'h555, 1'b1, 2'b11, 0, rc, uc, ic, sc, fc, bz, lt, li, rs, rd, re);
        checks++; if (rc != 3 || sc != 1 || ic != 0 || {rs, rd, re} !== 3'b100) begin errors++; $display("FAIL e_rd: resp %0d sh %0d inv %0d flags %b want 3 1 0 100", rc, sc, ic, {rs, rd, re}); end
        run_txn(2'b11, 12'h555, 1'b1, 2'b01, 0, rc, uc, ic, sc, fc, bz, lt, li, rs, rd, re);
        checks++; if (rc != 3 || ic != 1 || {rs, rd, re} !== 3'b100) begin errors++; $display("FAIL s_upgr: resp %0d inv %0d flags %b want 3 1 100", rc, ic, {rs, rd, re}); end
        run_txn(2'b11, 12'h555, 1'b1, 2'b11, 0, rc, uc, ic, sc, fc, bz, lt, li, rs, rd, re);
        checks++; if (rc != 3 || ic != 1 || {rs, rd, re} !== 3'b101) begin errors++; $display("FAIL e_upgr_err: resp %0d inv %0d flags %b want 3 1 101", rc, ic, {rs, rd, re}); end
        run_txn(2'b10, 12'h555, 1'b1, 2'b11, -1, rc, uc, ic, sc, fc, bz, lt, li, rs, rd, re);
        checks++; if (rc != 3 || fc != 0 || {rs, rd, re} !== 3'b100) begin errors++; $display("FAIL done_outside_flush: resp %0d flush %0d flags %b want 3 0 100", rc, fc, {rs, rd, re}); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] busy_v, resp_v, ready_v;
        busy_v = '0; resp_v = '0; ready_v = '0;
        snp_valid = 1; snp_cmd = 2'b01; snp_addr = 12'h050; lkup_hit = 0;
        @(posedge clk); #1;
        for (int c = 1; c <= 7; c++) begin
            busy_v[c] = o_busy; resp_v[c] = o_resp_valid; ready_v[c] = o_snp_ready;
            if (c == 5) snp_valid = 0;
            @(posedge clk); #1;
        end
        checks++; if (busy_v[7:1] !== 7'b0011011) begin errors++; $display("FAIL b2b_busy: got %b want 0011011", busy_v[7:1]); end
        checks++; if (resp_v[7:1] !== 7'b0010010) begin errors++; $display("FAIL b2b_resp: got %b want 0010010", resp_v[7:1]); end
        checks++; if (ready_v[7:1] !== 7'b1100100) begin errors++; $display("FAIL b2b_ready: got %b want 1100100", ready_v[7:1]); end
    endtask

    task automatic test_reset_mid_flush;
        int pulses;
        pulses = 0;
        snp_valid = 1; snp_cmd = 2'b01; snp_addr = 12'h1A4; lkup_hit = 1; lkup_mesi = 2'b10;
        @(posedge clk); #1;
        snp_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (o_flush_req !== 1'b1) begin errors++; $display("FAIL rst_flush_pre: got %b want 1", o_flush_req); end
        nrst = 0;
        #1;
        checks++; if ({o_busy, o_flush_req, o_set_invalidate, o_set_shared, o_resp_valid, o_proto_err, o_lkup_tag, o_lkup_index} !== 14'h0)
            begin errors++; $display("FAIL rst_mid_outputs: got %b want all zero", {o_busy, o_flush_req, o_set_invalidate, o_set_shared, o_resp_valid, o_proto_err, o_lkup_tag, o_lkup_index}); end
        @(negedge clk); nrst = 1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (o_set_invalidate || o_set_shared || o_flush_req || o_resp_valid || !o_snp_ready) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_after: active cycles %0d want 0", pulses); end
    endtask

    initial begin
        test_reset;
        test_miss;
        test_invalidate_e;
        test_flush_done;
        test_flush_timeout;
        test_other_hits;
        test_back_to_back;
        test_reset_mid_flush;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
